id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly downstream of the decode Control unit in the 5-stage MIPS pipeline.
- Each cycle it registers the decoded control bundle, operands, immediate and register indices for EX.
- Resolves destination register from RegDst at capture.
- Detects load-use hazards: raises a stall to freeze PC and IF/ID, and inserts a bubble.
- Honours branch/jump/IRQ flush and an external hold from the memory side.

---
 rtl/pipeline_pkg.sv | 54 +++++
 rtl/id_ex_stage_if.sv | 98 +++++++++
 rtl/load_use_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings and control-bundle type for the ID/EX pipeline slice.
// Optional perf counters in id_ex_stage are enabled by defining ID_EX_PERF_EN.
package pipeline_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned RW_DEF = 5;
    localparam int unsigned AOPW   = 4;
    localparam int unsigned PERFW  = 32;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_ZERO = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC  = 2'b10
    } memtoreg_e;

    localparam logic [4:0] REG_RA = 5'd31;

    // Decoded control travelling with the instruction; cleared or loaded as one unit.
    typedef struct packed {
        logic            branch;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            alusrc1;
        logic            alusrc2;
        logic [1:0]      memtoreg;
        logic [AOPW-1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [4:0] resolve_dst(input logic [1:0] regdst,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        logic [4:0] dst;
        dst = 5'd0;
        case (regdst)
            REGDST_RT:   dst = rt;
            REGDST_RD:   dst = rd;
            REGDST_RA:   dst = REG_RA;
            REGDST_ZERO: dst = 5'd0;
            default:     dst = 5'd0;
        endcase
        return dst;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bus: ID-side instruction fields in, registered EX slot out.
// Perf counter signals exist only when ID_EX_PERF_EN is defined.
interface id_ex_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic [5:0]    id_funct;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_branch;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_alusrc1;
    logic          id_alusrc2;
    logic [1:0]    id_regdst;
    logic [1:0]    id_memtoreg;
    logic [3:0]    id_aluop;
    logic          flush;
    logic          hold;

    logic          load_use_stall;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_shamt;
    logic [5:0]    ex_funct;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_dst;
    logic          ex_branch;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_alusrc1;
    logic          ex_alusrc2;
    logic [1:0]    ex_memtoreg;
    logic [3:0]    ex_aluop;

`ifdef ID_EX_PERF_EN
    logic [31:0]   perf_bubbles;
    logic [31:0]   perf_flushes;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt, id_funct,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2,
               id_regdst, id_memtoreg, id_aluop, flush, hold,
        input  load_use_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_shamt,
               ex_funct, ex_rs, ex_rt, ex_dst, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_memtoreg, ex_aluop,
               perf_bubbles, perf_flushes
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt, id_funct,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2,
               id_regdst, id_memtoreg, id_aluop, flush, hold,
        output load_use_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_shamt,
               ex_funct, ex_rs, ex_rt, ex_dst, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_memtoreg, ex_aluop,
               perf_bubbles, perf_flushes
    );
`else
    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt, id_funct,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2,
               id_regdst, id_memtoreg, id_aluop, flush, hold,
        input  load_use_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_shamt,
               ex_funct, ex_rs, ex_rt, ex_dst, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_memtoreg, ex_aluop
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt, id_funct,
               id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_branch, id_regwrite, id_memread, id_memwrite, id_alusrc1, id_alusrc2,
               id_regdst, id_memtoreg, id_aluop, flush, hold,
        output load_use_stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_shamt,
               ex_funct, ex_rs, ex_rt, ex_dst, ex_branch, ex_regwrite, ex_memread,
               ex_memwrite, ex_alusrc1, ex_alusrc2, ex_memtoreg, ex_aluop
    );
`endif

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the EX slot and the ID instruction.
module load_use_detect #(
    parameter int unsigned RW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_dst,
    input  logic          id_valid,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          flush,
    output logic          raw_hz_c,
    output logic          load_use_stall_c
);

    logic rs_match;
    logic rt_match;

    // A load writing $0 produces nothing to wait for.
    assign rs_match = id_uses_rs && (id_rs == ex_dst);
    assign rt_match = id_uses_rt && (id_rt == ex_dst);

    assign raw_hz_c = ex_valid && ex_memread && id_valid && (ex_dst != '0)
                      && (rs_match || rt_match);

    // A flushed ID instruction is being discarded, so there is nothing to freeze for.
    assign load_use_stall_c = raw_hz_c && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and external hold.
// Define ID_EX_PERF_EN to add saturating bubble/flush counters.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [5:0]    funct;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dst;
        ctrl_t         ctrl;
    } ex_slot_t;

    ex_slot_t slot_q;
    ex_slot_t slot_d;
    ctrl_t    id_ctrl;
    logic     raw_hz;
    logic     load_use_stall;
    logic     bubble;

    assign id_ctrl = '{
        branch:   bus.id_branch,
        regwrite: bus.id_regwrite,
        memread:  bus.id_memread,
        memwrite: bus.id_memwrite,
        alusrc1:  bus.id_alusrc1,
        alusrc2:  bus.id_alusrc2,
        memtoreg: bus.id_memtoreg,
        aluop:    bus.id_aluop
    };

    load_use_detect #(.RW(RW)) u_load_use_detect (
        .ex_valid         (slot_q.valid),
        .ex_memread       (slot_q.ctrl.memread),
        .ex_dst           (slot_q.dst),
        .id_valid         (bus.id_valid),
        .id_uses_rs       (bus.id_uses_rs),
        .id_uses_rt       (bus.id_uses_rt),
        .id_rs            (bus.id_rs),
        .id_rt            (bus.id_rt),
        .flush            (bus.flush),
        .raw_hz_c         (raw_hz),
        .load_use_stall_c (load_use_stall)
    );

    // Bubble only when neither flush nor hold takes precedence.
    assign bubble = !bus.flush && !bus.hold && raw_hz;

    // Next slot: flush > hold > load-use bubble > load.
    always_comb begin
        slot_d = slot_q;
        if (bus.flush || bubble) begin
            slot_d = '0;
        end else if (!bus.hold) begin
            slot_d.valid   = bus.id_valid;
            slot_d.pc      = bus.id_pc;
            slot_d.rs_data = bus.id_rs_data;
            slot_d.rt_data = bus.id_rt_data;
            slot_d.imm     = bus.id_imm;
            slot_d.shamt   = bus.id_shamt;
            slot_d.funct   = bus.id_funct;
            slot_d.rs      = bus.id_rs;
            slot_d.rt      = bus.id_rt;
            slot_d.dst     = RW'(resolve_dst(bus.id_regdst, 5'(bus.id_rt), 5'(bus.id_rd)));
            slot_d.ctrl    = bus.id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign bus.load_use_stall = load_use_stall;
    assign bus.ex_valid       = slot_q.valid;
    assign bus.ex_pc          = slot_q.pc;
    assign bus.ex_rs_data     = slot_q.rs_data;
    assign bus.ex_rt_data     = slot_q.rt_data;
    assign bus.ex_imm         = slot_q.imm;
    assign bus.ex_shamt       = slot_q.shamt;
    assign bus.ex_funct       = slot_q.funct;
    assign bus.ex_rs          = slot_q.rs;
    assign bus.ex_rt          = slot_q.rt;
    assign bus.ex_dst         = slot_q.dst;
    assign bus.ex_branch      = slot_q.ctrl.branch;
    assign bus.ex_regwrite    = slot_q.ctrl.regwrite;
    assign bus.ex_memread     = slot_q.ctrl.memread;
    assign bus.ex_memwrite    = slot_q.ctrl.memwrite;
    assign bus.ex_alusrc1     = slot_q.ctrl.alusrc1;
    assign bus.ex_alusrc2     = slot_q.ctrl.alusrc2;
    assign bus.ex_memtoreg    = slot_q.ctrl.memtoreg;
    assign bus.ex_aluop       = slot_q.ctrl.aluop;

`ifdef ID_EX_PERF_EN
    localparam logic [PERFW-1:0] PERF_MAX = '1;

    logic [PERFW-1:0] perf_bubbles_q;
    logic [PERFW-1:0] perf_flushes_q;

    // Saturating event counters; a plain hold counts nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (bubble && (perf_bubbles_q != PERF_MAX)) begin
                perf_bubbles_q <= perf_bubbles_q + PERFW'(1);
            end
            if (bus.flush && (perf_flushes_q != PERF_MAX)) begin
                perf_flushes_q <= perf_flushes_q + PERFW'(1);
            end
        end
    end

    assign bus.perf_bubbles = perf_bubbles_q;
    assign bus.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (perf checks when ID_EX_PERF_EN is defined).
module tb_id_ex_stage;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    id_ex_stage_if bus ();

    id_ex_stage u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid    = 1'b0;
        bus.id_pc       = '0;
        bus.id_rs_data  = '0;
        bus.id_rt_data  = '0;
        bus.id_imm      = '0;
        bus.id_shamt    = '0;
        bus.id_funct    = '0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_rd       = '0;
        bus.id_uses_rs  = 1'b0;
        bus.id_uses_rt  = 1'b0;
        bus.id_branch   = 1'b0;
        bus.id_regwrite = 1'b0;
        bus.id_memread  = 1'b0;
        bus.id_memwrite = 1'b0;
        bus.id_alusrc1  = 1'b0;
        bus.id_alusrc2  = 1'b0;
        bus.id_regdst   = '0;
        bus.id_memtoreg = '0;
        bus.id_aluop    = '0;
    endtask

    task automatic id_instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic urs, input logic urt,
                            input logic [1:0] regdst, input logic memread,
                            input logic regwrite, input logic [1:0] mtr);
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_pc       = pc;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_uses_rs  = urs;
        bus.id_uses_rt  = urt;
        bus.id_regdst   = regdst;
        bus.id_memread  = memread;
        bus.id_regwrite = regwrite;
        bus.id_memtoreg = mtr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        bus.flush    = 1'b0;
        bus.hold     = 1'b0;
        id_instr(32'hdead, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01);
        repeat (2) step();
        chk("rst_valid",   32'(bus.ex_valid), 32'd0);
        chk("rst_pc",      bus.ex_pc, 32'd0);
        chk("rst_dst",     32'(bus.ex_dst), 32'd0);
        chk("rst_memread", 32'(bus.ex_memread), 32'd0);
        chk("rst_regwr",   32'(bus.ex_regwrite), 32'd0);
        chk("rst_stall",   32'(bus.load_use_stall), 32'd0);
`ifdef ID_EX_PERF_EN
        chk("rst_pbub",    bus.perf_bubbles, 32'd0);
        chk("rst_pfl",     bus.perf_flushes, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // lw $8 then dependent add: one bubble
        id_instr(32'h104, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        bus.id_imm = 32'h10; bus.id_aluop = 4'd2; bus.id_alusrc2 = 1'b1;
        #1 chk("lw_nostall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("lw_valid",   32'(bus.ex_valid), 32'd1);
        chk("lw_dst",     32'(bus.ex_dst), 32'd8);
        chk("lw_memread", 32'(bus.ex_memread), 32'd1);
        chk("lw_pc",      bus.ex_pc, 32'h104);
        chk("lw_imm",     bus.ex_imm, 32'h10);
        chk("lw_mtr",     32'(bus.ex_memtoreg), 32'd1);
        chk("lw_alusrc2", 32'(bus.ex_alusrc2), 32'd1);
        chk("lw_aluop",   32'(bus.ex_aluop), 32'd2);
        chk("lw_rs",      32'(bus.ex_rs), 32'd9);
        id_instr(32'h108, 5'd8, 5'd10, 5'd12, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        bus.id_funct = 6'h20; bus.id_rs_data = 32'h55;
        #1 chk("use_stall", 32'(bus.load_use_stall), 32'd1);
        step();
        chk("bub_valid",   32'(bus.ex_valid), 32'd0);
        chk("bub_memread", 32'(bus.ex_memread), 32'd0);
        chk("bub_regwr",   32'(bus.ex_regwrite), 32'd0);
        chk("bub_pc",      bus.ex_pc, 32'd0);
        chk("bub_stall",   32'(bus.load_use_stall), 32'd0);
        step();
        chk("add_valid",  32'(bus.ex_valid), 32'd1);
        chk("add_dst",    32'(bus.ex_dst), 32'd12);
        chk("add_funct",  32'(bus.ex_funct), 32'h20);
        chk("add_pc",     bus.ex_pc, 32'h108);
        chk("add_rsdata", bus.ex_rs_data, 32'h55);

        // lw $0 followed by a reader of $0: no stall
        id_instr(32'h10c, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        step();
        chk("lw0_dst",  32'(bus.ex_dst), 32'd0);
        chk("lw0_mrd",  32'(bus.ex_memread), 32'd1);
        id_instr(32'h110, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        #1 chk("zero_stall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("zero_valid", 32'(bus.ex_valid), 32'd1);
        chk("zero_pc",    bus.ex_pc, 32'h110);
        chk("zero_dst",   32'(bus.ex_dst), 32'd3);

        // lw $8, lw $9, user of $9: one bubble
        id_instr(32'h114, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        step();
        id_instr(32'h118, 5'd3, 5'd9, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        #1 chk("lwlw_nostall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("lwlw_dst", 32'(bus.ex_dst), 32'd9);
        id_instr(32'h11c, 5'd9, 5'd4, 5'd6, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        #1 chk("lwlw_stall", 32'(bus.load_use_stall), 32'd1);
        step();
        chk("lwlw_bub", 32'(bus.ex_valid), 32'd0);
        step();
        chk("lwlw_pc",  bus.ex_pc, 32'h11c);
        chk("lwlw_dst6", 32'(bus.ex_dst), 32'd6);

        // jal
        id_instr(32'h200, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b10);
        bus.id_branch = 1'b1;
        step();
        chk("jal_dst", 32'(bus.ex_dst), 32'd31);
        chk("jal_mtr", 32'(bus.ex_memtoreg), 32'd2);
        chk("jal_pc",  bus.ex_pc, 32'h200);
        chk("jal_br",  32'(bus.ex_branch), 32'd1);

        // flush + hold + raw hazard together
        id_instr(32'h204, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        step();
        id_instr(32'h208, 5'd8, 5'd2, 5'd12, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        bus.flush = 1'b1; bus.hold = 1'b1;
        #1 chk("fh_stall", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("fh_valid", 32'(bus.ex_valid), 32'd0);
        chk("fh_mrd",   32'(bus.ex_memread), 32'd0);
        chk("fh_dst",   32'(bus.ex_dst), 32'd0);
        bus.flush = 1'b0; bus.hold = 1'b0;
        step();
        chk("fh_reload", bus.ex_pc, 32'h208);

        // hold for three cycles with a changing ID
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.id_pc = 32'h300 + 32'(4 * i);
            bus.id_rd = 5'(20 + i);
            step();
            chk("hold_pc",  bus.ex_pc, 32'h208);
            chk("hold_dst", 32'(bus.ex_dst), 32'd12);
        end
        bus.hold = 1'b0;
        step();
        chk("unhold_pc",  bus.ex_pc, 32'h308);
        chk("unhold_dst", 32'(bus.ex_dst), 32'd22);

        // hazard during hold: stall asserted, EX frozen, bubble after hold drops
        id_instr(32'h400, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        step();
        id_instr(32'h404, 5'd8, 5'd2, 5'd5, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        bus.hold = 1'b1;
        #1 chk("hh_stall", 32'(bus.load_use_stall), 32'd1);
        step();
        chk("hh_pc",  bus.ex_pc, 32'h400);
        chk("hh_mrd", 32'(bus.ex_memread), 32'd1);
        bus.hold = 1'b0;
        step();
        chk("hh_bub", 32'(bus.ex_valid), 32'd0);
        step();
        chk("hh_pc2", bus.ex_pc, 32'h404);

        // invalid ID slot: control zeroed, regdst 11 -> $0
        id_instr(32'h500, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 2'b01);
        bus.id_valid = 1'b0;
        step();
        chk("inv_valid", 32'(bus.ex_valid), 32'd0);
        chk("inv_regwr", 32'(bus.ex_regwrite), 32'd0);
        chk("inv_mrd",   32'(bus.ex_memread), 32'd0);
        chk("inv_mtr",   32'(bus.ex_memtoreg), 32'd0);
        chk("inv_pc",    bus.ex_pc, 32'h500);
        chk("inv_dst",   32'(bus.ex_dst), 32'd0);
`ifdef ID_EX_PERF_EN
        chk("perf_bub",  bus.perf_bubbles, 32'd3);
        chk("perf_fl",   bus.perf_flushes, 32'd1);
`endif

        // reset during a stall
        id_instr(32'h600, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01);
        step();
        id_instr(32'h604, 5'd8, 5'd2, 5'd5, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00);
        #1 chk("mr_stall", 32'(bus.load_use_stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid",  32'(bus.ex_valid), 32'd0);
        chk("mr_pc",     bus.ex_pc, 32'd0);
        chk("mr_stall0", 32'(bus.load_use_stall), 32'd0);
`ifdef ID_EX_PERF_EN
        chk("mr_pbub",   bus.perf_bubbles, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
